// File: rtl/mem_bus_scheduler.sv
// mem_bus_scheduler: arbitrates the single external AXI master port between the
// instruction cache and the data cache. Data wins ties; a grant is held until
// the final AXI response (txn_done) or a watchdog abort.
//
// Build option: define MEM_BUS_STARVE_GUARD_EN to force an instruction grant
// after MAX_DGRANTS consecutive data grants taken while an instruction request
// was waiting. Without it, data priority is strict.
//
// Requests are registered before the FSM uses them. The request registers are
// cleared on the edge that ends a grant, so the released cache's stale request
// is never seen again. As a result a grant appears one edge after its request
// is sampled, and at least one idle cycle separates consecutive grants.

module mem_bus_scheduler #(
    parameter int unsigned MAX_DGRANTS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic txn_done,
    output logic i_gnt,
    output logic d_gnt,
    output logic sel,
    output logic busy,
    output logic timeout_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrantI = 2'd1;
    localparam logic [1:0] StGrantD = 2'd2;

    // Reject parameter values the counters cannot represent.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_bus_scheduler: TIMEOUT_CYCLES must be at least 2");
    end
    if (MAX_DGRANTS == 0 || MAX_DGRANTS > 15) begin : g_bad_max_dgrants
        $error("mem_bus_scheduler: MAX_DGRANTS must be in 1..15");
    end

    logic [1:0]     state_q, state_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           i_req_q, d_req_q;
    logic           tmo_d;
    logic           grant_end;
    logic           pick_d;

`ifdef MEM_BUS_STARVE_GUARD_EN
    localparam logic [3:0] StarveLimit = 4'(MAX_DGRANTS);
    logic [3:0] starve_q;

    // Data wins unless instruction fetch has waited through StarveLimit data grants.
    assign pick_d = d_req_q && !(i_req_q && (starve_q == StarveLimit));

    // Count data grants taken while an instruction request was waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else if (state_q == StIdle && state_d == StGrantD) begin
            starve_q <= i_req_q ? starve_q + 4'd1 : 4'd0;
        end else if (state_q == StIdle && state_d == StGrantI) begin
            starve_q <= 4'd0;
        end
    end
`else
    assign pick_d = d_req_q;
`endif

    // Next state, watchdog count and abort decision.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        tmo_d     = 1'b0;
        grant_end = 1'b0;
        case (state_q)
            StIdle: begin
                // Holding zero in idle means every grant starts with a clear count.
                wd_d = '0;
                if (pick_d) begin
                    state_d = StGrantD;
                end else if (i_req_q) begin
                    state_d = StGrantI;
                end
            end
            StGrantI, StGrantD: begin
                if (txn_done) begin
                    state_d   = StIdle;
                    grant_end = 1'b1;
                end else if (wd_q == WdLast) begin
                    state_d   = StIdle;
                    tmo_d     = 1'b1;
                    grant_end = 1'b1;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            i_req_q     <= 1'b0;
            d_req_q     <= 1'b0;
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            sel         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            i_req_q     <= grant_end ? 1'b0 : i_req;
            d_req_q     <= grant_end ? 1'b0 : d_req;
            i_gnt       <= (state_d == StGrantI);
            d_gnt       <= (state_d == StGrantD);
            sel         <= (state_d == StGrantD);
            busy        <= (state_d != StIdle);
            timeout_err <= tmo_d;
        end
    end

endmodule

// File: doc/mem_bus_scheduler.md
# mem_bus_scheduler

Sequential arbiter sharing the core's single external AXI master port between the instruction cache and the data cache. Each cache raises a request on a miss or write-back, the scheduler grants exactly one of them, and holds that grant until the AXI side reports that transaction's final response. It drives the steering select for the AXI channel muxes, and adds a per-transaction watchdog plus optional anti-starvation for instruction fetch.

## Interface
- MAX_DGRANTS, 4: consecutive data grants allowed while an instruction request waits (guard builds only); range 1..15.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles per granted transaction; at least 2, power of two not required.
- clk  in  1  core clock (same clock as the AXI interface).
- rst_n  in  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- i_req  in  1  instruction cache requests the bus; held high until its grant ends.
- d_req  in  1  data cache requests the bus; held high until its grant ends.
- txn_done  in  1  one-cycle pulse on the final handshake of the granted transaction (RVALID&RREADY&RLAST, or BVALID&BREADY).
- i_gnt  out  1  instruction cache owns the AXI port.
- d_gnt  out  1  data cache owns the AXI port.
- sel  out  1  AXI channel steering: 1 = data cache, 0 = instruction cache or idle.
- busy  out  1  a grant is active.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_I: i_gnt=1, sel=0.
  - GRANT_D: d_gnt=1, sel=1.
- IDLE with d_req=1 goes to GRANT_D, unless the starvation rule selects I.
- IDLE with only i_req=1 goes to GRANT_I.
- IDLE with no request stays in IDLE.
- Simultaneous i_req and d_req: data wins by default, because a load/store miss blocks the current instruction.
- GRANT_x stays in place until txn_done=1, then returns to IDLE.
- There is always at least one IDLE cycle between grants. This gives the released cache one cycle to drop its request.
- A request dropped during its own grant does not end the grant. Only txn_done or the watchdog can end it, since AXI transactions cannot be aborted.
- txn_done while in IDLE is ignored.
- Watchdog:
  - A counter clears on entry to any GRANT state and increments every granted cycle.
  - When it reaches TIMEOUT_CYCLES-1 without txn_done, pulse timeout_err for one cycle and go to IDLE.
  - If txn_done and timeout occur in the same cycle, txn_done wins and timeout_err stays 0.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- i_gnt and d_gnt are never high together. busy = i_gnt | d_gnt.

## Timing
- All outputs are registered. Reset values: i_gnt=0, d_gnt=0, sel=0, busy=0, timeout_err=0. State is IDLE; watchdog and starvation counters are 0.
- Grant latency: a request sampled high in IDLE at edge N shows its grant after edge N+1.
- Release: txn_done high at edge N clears the grant after edge N. The next grant is visible after edge N+2 at the earliest.
- sel changes only on grant transitions. It is stable for the entire grant, so the mux never switches mid-burst.
- Reset asserted mid-grant drops the grant at the next edge, with no txn_done required. The AXI slave side is reset on the same rst_n.
- timeout_err is high for exactly the single cycle following the edge on which the abort is taken.

## Configuration
- MEM_BUS_STARVE_GUARD_EN defined:
  - A 4-bit starvation counter increments each time GRANT_D is entered while i_req=1.
  - It clears when GRANT_I is entered, and when GRANT_D is entered with i_req=0.
  - In IDLE with both requests high and the counter equal to MAX_DGRANTS, the scheduler goes to GRANT_I instead.
  - The counter resets to 0.
- MEM_BUS_STARVE_GUARD_EN undefined: strict data priority. No counter exists and MAX_DGRANTS is unused.

## Test plan
- Reset, then i_req=1 only; txn_done pulse 8 cycles after the grant:
  - i_gnt=1 and sel=0 one cycle after the request is sampled.
  - Grant clears the cycle after txn_done.
  - busy tracks i_gnt throughout.
- i_req and d_req rise together:
  - d_gnt=1 and sel=1 first.
  - After txn_done, one IDLE cycle, then i_gnt=1.
  - Grants never overlap.
- Guard build, MAX_DGRANTS=2; i_req held and d_req re-asserted after every release:
  - Grant order D, D, I, D, D, I.
  - Without the macro: D indefinitely while d_req keeps re-asserting.
- TIMEOUT_CYCLES=16; grant D and never pulse txn_done:
  - timeout_err pulses once, 16 cycles after grant entry.
  - d_gnt=0 on that same cycle; FSM returns to IDLE and can grant again.
- rst_n=0 for one cycle during GRANT_D:
  - All outputs return to 0 on the next cycle.
  - A stale txn_done after reset produces no grant change.
- d_req dropped mid-grant:
  - d_gnt remains 1 until txn_done.
  - txn_done pulsed in IDLE has no effect.
